key_expander_seq: RTL and testbench

- Iterative AES key schedule. Sits directly upstream of the combinational cipher datapath and produces the full expanded round-key word array for it.
- Computes one 32-bit schedule word per clock, using a single 4-byte S-box instance instead of a fully unrolled expansion.
- Supports AES-128/192/256 through the same Nb/Nk/Nr parameter set the cipher uses.
- The flattened output plugs directly into the cipher's round-key input once keys_valid is high.

---
 rtl/aes_pkg.sv | 45 ++++
 rtl/aes_sbox_word.sv | 14 +
 rtl/key_expander_seq.sv | 158 +++++++++++++++
 tb/tb_key_expander_seq.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants and types for the key-schedule block.
// Holds the S-box table, the round constants, the controller state type
// and the helper that sizes the expanded key array.
package aes_pkg;

    // Controller states of the iterative key expander
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Number of 32-bit schedule words: one Nb-word round key per round plus the initial one
    function automatic int total_words(input int nb, input int nr);
        return nb * (nr + 1);
    endfunction

    // Round constants, indexed by i/Nk (1..10); unused slots are zero so
    // an over-run of the index counter past the last word reads harmlessly
    localparam logic [0:15][7:0] RCON = {
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    // Forward AES S-box, entry 0 first
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

endpackage

// File: rtl/aes_sbox_word.sv
// SubWord: applies the AES S-box to each byte of a 32-bit word.
// Purely combinational, four parallel table lookups.
module aes_sbox_word
    import aes_pkg::*;
(
    input  logic [31:0] word,
    output logic [31:0] sub_word
);

    // Bytewise substitution, byte order preserved
    assign sub_word = {SBOX[word[31:24]], SBOX[word[23:16]],
                       SBOX[word[15:8]],  SBOX[word[7:0]]};

endmodule

// File: rtl/key_expander_seq.sv
// Iterative AES key schedule: one 32-bit schedule word per clock through a
// single shared SubWord unit. Supports AES-128/192/256 via Nk/Nr.
// Optional macro KEYEXP_RK_PORT_EN adds a registered per-round key read port
// (rk_idx -> rk, one cycle latency).
module key_expander_seq
    import aes_pkg::*;
#(
    parameter int Nb = 4,
    parameter int Nk = 4,
    parameter int Nr = 10
)
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [32*Nk-1:0]          key,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      keys_valid,
    output logic [32*Nb*(Nr+1)-1:0]   word_flat
`ifdef KEYEXP_RK_PORT_EN
    ,
    input  logic [3:0]                rk_idx,
    output logic [127:0]              rk
`endif
);

    localparam int TW = total_words(Nb, Nr);
    localparam int IW = $clog2(TW + 1);

    state_t          state;
    logic [31:0]     w [TW];
    logic [IW-1:0]   idx;       // i: index of the word written this cycle
    logic [2:0]      kmod;      // i mod Nk
    logic [3:0]      rci;       // i / Nk, the Rcon index

    logic [IW-1:0]   prev_idx;
    logic [IW-1:0]   back_idx;
    logic [31:0]     prev_word;
    logic [31:0]     back_word;
    logic [31:0]     sub_in;
    logic [31:0]     sub_out;
    logic [31:0]     temp;
    logic [31:0]     new_word;
    logic            last_word;

    assign prev_idx  = idx - IW'(1);
    assign back_idx  = idx - IW'(Nk);
    assign prev_word = w[prev_idx];
    assign back_word = w[back_idx];
    assign last_word = (idx == IW'(TW - 1));

    // RotWord only applies on the Rcon steps; the 256-bit mid-key step uses plain SubWord
    assign sub_in = (kmod == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;

    aes_sbox_word u_sbox (
        .word     (sub_in),
        .sub_word (sub_out)
    );

    // Next schedule word w[i] = w[i-Nk] xor temp
    always_comb begin
        temp = prev_word;
        if (kmod == 3'd0) begin
            temp = sub_out ^ {RCON[rci], 24'h000000};
        end else if (Nk > 6 && kmod == 3'd4) begin
            temp = sub_out;
        end
        new_word = back_word ^ temp;
    end

    // Controller and word storage: capture key, expand one word per cycle, flag completion
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            keys_valid <= 1'b0;
            idx        <= '0;
            kmod       <= '0;
            rci        <= '0;
            for (int k = 0; k < TW; k++) begin
                w[k] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int k = 0; k < Nk; k++) begin
                            w[k] <= key[32*(Nk-1-k) +: 32];
                        end
                        idx        <= IW'(Nk);
                        kmod       <= 3'd0;
                        rci        <= 4'd1;
                        keys_valid <= 1'b0;
                        busy       <= 1'b1;
                        state      <= EXPAND;
                    end
                end
                EXPAND: begin
                    w[idx] <= new_word;
                    idx    <= idx + IW'(1);
                    if (kmod == 3'(Nk - 1)) begin
                        kmod <= 3'd0;
                        rci  <= rci + 4'd1;
                    end else begin
                        kmod <= kmod + 3'd1;
                    end
                    if (last_word) begin
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        keys_valid <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Flatten the word array, w[0] at the MSB end
    always_comb begin
        word_flat = '0;
        for (int k = 0; k < TW; k++) begin
            word_flat[32*(TW-k)-1 -: 32] = w[k];
        end
    end

`ifdef KEYEXP_RK_PORT_EN
    logic [127:0] rk_next;

    // Select the four words of round key rk_idx; out-of-range rounds read as zero
    always_comb begin
        rk_next = '0;
        for (int r = 0; r <= Nr; r++) begin
            if (rk_idx == 4'(r)) begin
                rk_next = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            end
        end
    end

    // Registered round-key read port
    always_ff @(posedge clk) begin
        if (rst) begin
            rk <= '0;
        end else begin
            rk <= rk_next;
        end
    end
`endif

endmodule

// File: tb/tb_key_expander_seq.sv
// Directed bench for key_expander_seq: one instance per AES key size,
// FIPS-197 vectors checked word by word, plus timing, start-while-busy,
// mid-expansion reset and (with KEYEXP_RK_PORT_EN) round-key port sequences.
module tb_key_expander_seq;

    localparam int W128 = 32*44;
    localparam int W192 = 32*52;
    localparam int W256 = 32*60;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [127:0]      key128 = '0;
    logic [191:0]      key192 = '0;
    logic [255:0]      key256 = '0;
    logic              start128 = 1'b0, start192 = 1'b0, start256 = 1'b0;
    logic              busy128, busy192, busy256;
    logic              done128, done192, done256;
    logic              kv128, kv192, kv256;
    logic [W128-1:0]   wf128;
    logic [W192-1:0]   wf192;
    logic [W256-1:0]   wf256;
`ifdef KEYEXP_RK_PORT_EN
    logic [3:0]        rk_idx128 = '0, rk_idx192 = '0, rk_idx256 = '0;
    logic [127:0]      rk128, rk192, rk256;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    key_expander_seq #(.Nb(4), .Nk(4), .Nr(10)) dut128 (
        .clk(clk), .rst(rst), .key(key128), .start(start128),
        .busy(busy128), .done(done128), .keys_valid(kv128), .word_flat(wf128)
`ifdef KEYEXP_RK_PORT_EN
        , .rk_idx(rk_idx128), .rk(rk128)
`endif
    );

    key_expander_seq #(.Nb(4), .Nk(6), .Nr(12)) dut192 (
        .clk(clk), .rst(rst), .key(key192), .start(start192),
        .busy(busy192), .done(done192), .keys_valid(kv192), .word_flat(wf192)
`ifdef KEYEXP_RK_PORT_EN
        , .rk_idx(rk_idx192), .rk(rk192)
`endif
    );

    key_expander_seq #(.Nb(4), .Nk(8), .Nr(14)) dut256 (
        .clk(clk), .rst(rst), .key(key256), .start(start256),
        .busy(busy256), .done(done256), .keys_valid(kv256), .word_flat(wf256)
`ifdef KEYEXP_RK_PORT_EN
        , .rk_idx(rk_idx256), .rk(rk256)
`endif
    );

    typedef struct {
        int          inst;   // 0: AES-128, 1: AES-192, 2: AES-256
        int          widx;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [$];

    localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_B = 128'hffeeddccbbaa99887766554433221100;

    function automatic logic [31:0] word_of(input int inst, input int k);
        case (inst)
            0:       return wf128[W128-1-32*k -: 32];
            1:       return wf192[W192-1-32*k -: 32];
            default: return wf256[W256-1-32*k -: 32];
        endcase
    endfunction

    function automatic logic done_of(input int inst);
        case (inst)
            0:       return done128;
            1:       return done192;
            default: return done256;
        endcase
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_start(input int inst, input logic v);
        case (inst)
            0:       start128 = v;
            1:       start192 = v;
            default: start256 = v;
        endcase
    endtask

    // Pulse start for one edge, then count edges until done is seen (bounded)
    task automatic run(input int inst, output int cyc);
        set_start(inst, 1'b1);
        @(posedge clk); #1;
        set_start(inst, 1'b0);
        cyc = 0;
        while (!done_of(inst) && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        int dones;
        int first_done;

        // AES-128 FIPS-197 A.1
        vecs.push_back('{0, 0,  32'h2b7e1516});
        vecs.push_back('{0, 3,  32'h09cf4f3c});
        vecs.push_back('{0, 4,  32'ha0fafe17});
        vecs.push_back('{0, 5,  32'h88542cb1});
        vecs.push_back('{0, 6,  32'h23a33939});
        vecs.push_back('{0, 7,  32'h2a6c7605});
        vecs.push_back('{0, 40, 32'hd014f9a8});
        vecs.push_back('{0, 41, 32'hc9ee2589});
        vecs.push_back('{0, 42, 32'he13f0cc8});
        vecs.push_back('{0, 43, 32'hb6630ca6});
        // AES-192, key 00..17
        vecs.push_back('{1, 0,  32'h00010203});
        vecs.push_back('{1, 5,  32'h14151617});
        vecs.push_back('{1, 6,  32'h5846f2f9});
        vecs.push_back('{1, 7,  32'h5c43f4fe});
        vecs.push_back('{1, 48, 32'ha4970a33});
        vecs.push_back('{1, 49, 32'h1a78dc09});
        vecs.push_back('{1, 50, 32'hc418c271});
        vecs.push_back('{1, 51, 32'he3a41d5d});
        // AES-256, key 00..1f
        vecs.push_back('{2, 7,  32'h1c1d1e1f});
        vecs.push_back('{2, 8,  32'ha573c29f});
        vecs.push_back('{2, 9,  32'ha176c498});
        vecs.push_back('{2, 56, 32'h24fc79cc});
        vecs.push_back('{2, 57, 32'hbf0979e9});
        vecs.push_back('{2, 58, 32'h371ac23c});
        vecs.push_back('{2, 59, 32'h6d68de36});

        key128 = KEY_A;
        key192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
        key256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy",  128'(busy128), 128'(0));
        check("rst_done",  128'(done128), 128'(0));
        check("rst_kv",    128'(kv128),   128'(0));
        check("rst_wf",    128'(|wf128),  128'(0));

        // AES-128 expansion and timing
        run(0, cyc);
        check("lat128", 128'(cyc), 128'(40));
        check("kv128_at_done", 128'(kv128), 128'(1));
        check("busy128_at_done", 128'(busy128), 128'(0));
        @(posedge clk); #1;
        check("done128_pulse", 128'(done128), 128'(0));
        check("kv128_hold", 128'(kv128), 128'(1));

        run(1, cyc);
        check("lat192", 128'(cyc), 128'(46));
        run(2, cyc);
        check("lat256", 128'(cyc), 128'(52));

        // Word-by-word schedule checks
        for (int v = 0; v < vecs.size(); v++) begin
            check($sformatf("w%0d_inst%0d", vecs[v].widx, vecs[v].inst),
                  128'(word_of(vecs[v].inst, vecs[v].widx)), 128'(vecs[v].exp));
        end

        // Start while busy: second start (different key) must be ignored
        key128 = KEY_A;
        start128 = 1'b1;
        @(posedge clk); #1;
        start128 = 1'b0;
        check("kv_drop_on_start", 128'(kv128), 128'(0));
        check("busy_after_start", 128'(busy128), 128'(1));
        dones = 0;
        first_done = -1;
        for (int c = 1; c <= 60; c++) begin
            if (c == 10) begin
                key128 = KEY_B;
                start128 = 1'b1;
            end
            @(posedge clk); #1;
            start128 = 1'b0;
            if (done128) begin
                dones++;
                if (first_done < 0) first_done = c;
            end
        end
        check("busy_start_dones", 128'(dones), 128'(1));
        check("busy_start_when", 128'(first_done), 128'(40));
        check("busy_start_w4",  128'(word_of(0, 4)),  128'(32'ha0fafe17));
        check("busy_start_w43", 128'(word_of(0, 43)), 128'(32'hb6630ca6));
        key128 = KEY_A;

        // Reset in the middle of an expansion
        start128 = 1'b1;
        @(posedge clk); #1;
        start128 = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_busy", 128'(busy128), 128'(0));
        check("midrst_kv",   128'(kv128),   128'(0));
        check("midrst_wf",   128'(|wf128),  128'(0));
        run(0, cyc);
        check("midrst_relat", 128'(cyc), 128'(40));
        check("midrst_w43", 128'(word_of(0, 43)), 128'(32'hb6630ca6));
        check("midrst_w0",  128'(word_of(0, 0)),  128'(32'h2b7e1516));

`ifdef KEYEXP_RK_PORT_EN
        // Registered round-key port
        rk_idx128 = 4'd0;
        @(posedge clk); #1;
        check("rk0", rk128, KEY_A);
        rk_idx128 = 4'd10;
        @(posedge clk); #1;
        check("rk10", rk128, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        rk_idx128 = 4'd15;
        @(posedge clk); #1;
        check("rk15", rk128, 128'h0);
        rk_idx128 = 4'd1;
        @(posedge clk); #1;
        check("rk1", rk128, 128'ha0fafe1788542cb123a339392a6c7605);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
